// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - request/response controller for the 16-bit ALU with in-block shift-add MUL
// Registers ALU operands, captures the result, and serialises one request at a time.
module alu_issue_ctrl #(
  parameter int WIDTH    = 16,
  parameter int MUL_ITER = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  input  logic [2:0]         req_opcode,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [2*WIDTH-1:0] resp_result,
  output logic [1:0]         resp_flags,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_opcode,
  input  logic [2*WIDTH-1:0] alu_result,
  output logic               busy
);

  localparam int CW = $clog2(MUL_ITER) + 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_ILL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_MUL   = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]   r_alu_a;
  logic [WIDTH-1:0]   r_alu_b;
  logic [2:0]         r_alu_op;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_resp_valid;
  logic [2*WIDTH-1:0] r_resp_result;
  logic [1:0]         r_resp_flags;

  logic               w_accept;
  logic               w_mul_last;
  logic               w_carry;
  logic               w_borrow;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_addend;

  assign w_accept   = (r_state == S_IDLE) && req_valid;
  assign w_mul_last = (r_cnt == CW'(MUL_ITER - 1));
  // A truncated sum wraps below either operand exactly when bit WIDTH would be set.
  assign w_carry    = (r_alu_a + r_alu_b) < r_alu_a;
  assign w_borrow   = r_alu_a < r_alu_b;
  assign w_addend   = r_mplier[0] ? r_mcand : '0;
  assign w_acc_next = r_acc + w_addend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_opcode == OP_MUL)      w_next = S_MUL;
          else if (req_opcode == OP_ILL) w_next = S_RESP;
          else                           w_next = S_ISSUE;
        end
      end
      S_ISSUE: w_next = S_RESP;
      S_MUL:   if (w_mul_last) w_next = S_RESP;
      S_RESP:  if (resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= OP_ADD;
      r_mcand       <= '0;
      r_mplier      <= '0;
      r_acc         <= '0;
      r_cnt         <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_result <= '0;
      r_resp_flags  <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (req_opcode == OP_MUL) begin
              r_alu_a  <= '0;
              r_alu_b  <= '0;
              r_alu_op <= OP_ADD;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_mcand  <= {{WIDTH{1'b0}}, req_a};
              r_mplier <= req_b;
            end else if (req_opcode == OP_ILL) begin
              r_resp_valid  <= 1'b1;
              r_resp_result <= '0;
              r_resp_flags  <= 2'b10;
            end else begin
              r_alu_a  <= req_a;
              r_alu_b  <= req_b;
              r_alu_op <= req_opcode;
            end
          end
        end
        S_ISSUE: begin
          r_resp_valid  <= 1'b1;
          r_resp_result <= alu_result;
          if (r_alu_op == OP_ADD)      r_resp_flags <= {1'b0, w_carry};
          else if (r_alu_op == OP_SUB) r_resp_flags <= {1'b0, w_borrow};
          else                         r_resp_flags <= 2'b00;
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_mul_last) begin
            r_resp_valid  <= 1'b1;
            r_resp_result <= w_acc_next;
            r_resp_flags  <= 2'b00;
          end
        end
        S_RESP: begin
          if (resp_ready) r_resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign resp_valid  = r_resp_valid;
  assign resp_result = r_resp_result;
  assign resp_flags  = r_resp_flags;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_opcode  = r_alu_op;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl
// Includes a behavioural model of the external combinational ALU.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [2:0]  req_opcode;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic [1:0]  resp_flags;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_result;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  alu_issue_ctrl #(.WIDTH(16), .MUL_ITER(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_flags(resp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_result = 32'h0;
    case (alu_opcode)
      3'b000: alu_result = {16'h0, alu_a} + {16'h0, alu_b};
      3'b010: alu_result = {16'h0, alu_a} - {16'h0, alu_b};
      3'b011: alu_result = {16'h0, alu_a & alu_b};
      3'b100: alu_result = {16'h0, alu_a | alu_b};
      3'b101: alu_result = {16'h0, alu_a ^ alu_b};
      3'b110: alu_result = ~{16'h0, alu_a};
      default: alu_result = 32'h0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready: req_ready=%b expected 1", req_ready);
    end
    req_valid  = 1'b1;
    req_a      = a;
    req_b      = b;
    req_opcode = op;
    tick();
    req_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_opcode = '0; resp_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_tests++;
    if ({req_ready, resp_valid, busy} !== 3'b100) begin
      n_fail++; $display("FAIL reset_ctrl: ready/valid/busy=%b expected 100", {req_ready, resp_valid, busy});
    end
    n_tests++;
    if ({resp_result, resp_flags} !== 34'h0) begin
      n_fail++; $display("FAIL reset_resp: result=%h flags=%b expected 0", resp_result, resp_flags);
    end
    n_tests++;
    if ({alu_a, alu_b, alu_opcode} !== 35'h0) begin
      n_fail++; $display("FAIL reset_alu: a=%h b=%h op=%b expected 0", alu_a, alu_b, alu_opcode);
    end
  endtask

  task automatic test_add();
    resp_ready = 1'b1;
    accept(16'hFFFF, 16'h0001, 3'b000);
    n_tests++;
    if ({alu_opcode, alu_a, busy, req_ready, resp_valid} !== {3'b000, 16'hFFFF, 3'b100}) begin
      n_fail++; $display("FAIL add_issue: op=%b a=%h busy=%b rdy=%b vld=%b expected 000 ffff 1 0 0",
                         alu_opcode, alu_a, busy, req_ready, resp_valid);
    end
    tick();
    n_tests++;
    if ({resp_valid, resp_result, resp_flags} !== {1'b1, 32'h00010000, 2'b01}) begin
      n_fail++; $display("FAIL add_resp: vld=%b result=%h flags=%b expected 1 00010000 01",
                         resp_valid, resp_result, resp_flags);
    end
    tick();
    n_tests++;
    if ({resp_valid, busy, req_ready} !== 3'b001) begin
      n_fail++; $display("FAIL add_done: vld/busy/rdy=%b expected 001", {resp_valid, busy, req_ready});
    end
  endtask

  task automatic test_sub_and();
    resp_ready = 1'b1;
    accept(16'd3, 16'd5, 3'b010);
    tick();
    n_tests++;
    if ({resp_valid, resp_result, resp_flags} !== {1'b1, 32'hFFFFFFFE, 2'b01}) begin
      n_fail++; $display("FAIL sub_resp: vld=%b result=%h flags=%b expected 1 fffffffe 01",
                         resp_valid, resp_result, resp_flags);
    end
    tick();
    accept(16'hF0F0, 16'hFF00, 3'b011);
    tick();
    n_tests++;
    if ({resp_valid, resp_result, resp_flags} !== {1'b1, 32'h0000F000, 2'b00}) begin
      n_fail++; $display("FAIL and_resp: vld=%b result=%h flags=%b expected 1 0000f000 00",
                         resp_valid, resp_result, resp_flags);
    end
    tick();
  endtask

  task automatic test_mul();
    int bad = 0;
    int cnt = 0;
    resp_ready = 1'b1;
    accept(16'hFFFF, 16'hFFFF, 3'b001);
    for (int i = 1; i < 16; i++) begin
      if ({busy, req_ready, alu_opcode, resp_valid} !== {2'b10, 3'b000, 1'b0}) bad++;
      tick();
    end
    n_tests++;
    if ({busy, req_ready, alu_opcode, resp_valid} !== {2'b10, 3'b000, 1'b0} || bad != 0) begin
      n_fail++; $display("FAIL mul_busy: bad_cycles=%0d busy=%b rdy=%b op=%b vld=%b expected 0 1 0 000 0",
                         bad, busy, req_ready, alu_opcode, resp_valid);
    end
    tick();
    n_tests++;
    if ({resp_valid, resp_result, resp_flags} !== {1'b1, 32'hFFFE0001, 2'b00}) begin
      n_fail++; $display("FAIL mul_max: vld=%b result=%h flags=%b expected 1 fffe0001 00",
                         resp_valid, resp_result, resp_flags);
    end
    tick();
    accept(16'h1234, 16'h0000, 3'b001);
    while (resp_valid !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    n_tests++;
    if (cnt != 16 || resp_result !== 32'h0) begin
      n_fail++; $display("FAIL mul_zero: latency=%0d result=%h expected 16 00000000", cnt, resp_result);
    end
    tick();
  endtask

  task automatic test_illegal();
    resp_ready = 1'b0;
    accept(16'h1111, 16'h0000, 3'b111);
    tick();
    n_tests++;
    if ({resp_valid, resp_result, resp_flags} !== {1'b1, 32'h0, 2'b10}) begin
      n_fail++; $display("FAIL illegal_resp: vld=%b result=%h flags=%b expected 1 00000000 10",
                         resp_valid, resp_result, resp_flags);
    end
    resp_ready = 1'b1;
    tick();
    n_tests++;
    if ({resp_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL illegal_done: vld/busy=%b expected 00", {resp_valid, busy});
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    resp_ready = 1'b0;
    accept(16'hAAAA, 16'h5555, 3'b101);
    tick();
    req_valid = 1'b1; req_a = 16'h0001; req_b = 16'h0001; req_opcode = 3'b000;
    for (int i = 0; i < 5; i++) begin
      if ({resp_valid, resp_result, resp_flags, req_ready} !== {1'b1, 32'h0000FFFF, 2'b00, 1'b0}) bad++;
      tick();
    end
    n_tests++;
    if (bad != 0 || alu_opcode !== 3'b101) begin
      n_fail++; $display("FAIL bp_hold: bad_cycles=%0d alu_op=%b expected 0 101", bad, alu_opcode);
    end
    resp_ready = 1'b1;
    tick();
    n_tests++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL bp_release: vld/rdy=%b expected 01", {resp_valid, req_ready});
    end
    tick();
    req_valid = 1'b0;
    n_tests++;
    if ({busy, alu_a, alu_opcode} !== {1'b1, 16'h0001, 3'b000}) begin
      n_fail++; $display("FAIL bp_new_accept: busy=%b a=%h op=%b expected 1 0001 000", busy, alu_a, alu_opcode);
    end
    tick();
    n_tests++;
    if ({resp_valid, resp_result} !== {1'b1, 32'h2}) begin
      n_fail++; $display("FAIL bp_new_resp: vld=%b result=%h expected 1 00000002", resp_valid, resp_result);
    end
    tick();
  endtask

  task automatic test_reset_mid_mul();
    int cnt = 0;
    resp_ready = 1'b1;
    accept(16'h00FF, 16'h0101, 3'b001);
    for (int i = 0; i < 6; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({resp_valid, busy, alu_a, alu_b, alu_opcode, resp_result, resp_flags} !== 70'h0) begin
      n_fail++; $display("FAIL rst_mid_mul: vld=%b busy=%b a=%h b=%h op=%b result=%h flags=%b expected all 0",
                         resp_valid, busy, alu_a, alu_b, alu_opcode, resp_result, resp_flags);
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid !== 1'b0) cnt++;
      tick();
    end
    n_tests++;
    if (cnt != 0) begin
      n_fail++; $display("FAIL rst_stale: stale valid cycles=%0d expected 0", cnt);
    end
    accept(16'd2, 16'd2, 3'b000);
    tick();
    n_tests++;
    if ({resp_valid, resp_result, resp_flags} !== {1'b1, 32'h4, 2'b00}) begin
      n_fail++; $display("FAIL rst_add: vld=%b result=%h flags=%b expected 1 00000004 00",
                         resp_valid, resp_result, resp_flags);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_and();
    test_mul();
    test_illegal();
    test_backpressure();
    test_reset_mid_mul();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
